serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 74 +++++++
 tb/tb_serial_adder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder, one full-adder bit per clock.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t          r_state, w_next;
    logic [WIDTH-1:0] r_as, r_b;
    logic            r_c;
    logic [CW-1:0]   r_cnt;
    logic            w_bit, w_carry, w_last;
    assign w_bit   = r_as[0] ^ r_b[0] ^ r_c;
    assign w_carry = (r_as[0] & r_b[0]) | (r_c & (r_as[0] ^ r_b[0]));
    assign w_last  = r_cnt == CW'(WIDTH - 1);
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = (r_state == IDLE)  ? (start  ? SHIFT : IDLE)  :
                 (r_state == SHIFT) ? (w_last ? DONE  : SHIFT) : IDLE;
    end
    always_comb begin
        busy = r_state == SHIFT;
        done = r_state == DONE;
    end
    // r_as holds operand A and fills with sum bits from the MSB side as A drains out
    always_ff @(posedge clk) begin
        if (rst) begin
            r_as    <= '0;
            r_b     <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            sum_out <= '0;
            cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf     <= 1'b0;
`endif
        end else if (r_state == IDLE && start) begin
            r_as  <= a_in;
            r_b   <= b_in;
            r_c   <= cin;
            r_cnt <= '0;
        end else if (r_state == SHIFT) begin
            r_as  <= {w_bit, r_as[WIDTH-1:1]};
            r_b   <= r_b >> 1;
            r_c   <= w_carry;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                sum_out <= {w_bit, r_as[WIDTH-1:1]};
                cout    <= w_carry;
`ifdef SERIAL_ADDER_OVF_EN
                ovf     <= r_c ^ w_carry;
`endif
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed scoreboard bench for serial_adder at WIDTH=8.
module tb_serial_adder;
    localparam int W = 8;
    typedef struct {logic [W-1:0] s; logic c; logic o;} exp_t;
    logic         clk = 1'b0;
    logic         rst, start, cin;
    logic [W-1:0] a_in, b_in;
    logic         busy, done, cout;
    logic [W-1:0] sum_out;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif
    int    errors = 0, checks = 0, cyc = 0, n_done = 0, busy_run = 0;
    int    done_edge[$];
    exp_t  sb[$];

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
        .busy(busy), .done(done), .sum_out(sum_out), .cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0] t;
        exp_t e;
        t   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        e.s = t[W-1:0];
        e.c = t[W];
        e.o = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) busy_run = 0;
        else begin
            if (busy) busy_run++;
            if (busy && done) chk("busy_and_done", 1, 0);
            if (done) begin
                exp_t e;
                n_done++;
                done_edge.push_back(cyc + 1);
                chk("busy_cycles", busy_run, W);
                busy_run = 0;
                chk("done_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("sum_out", sum_out, e.s);
                    chk("cout", cout, e.c);
`ifdef SERIAL_ADDER_OVF_EN
                    chk("ovf", ovf, e.o);
`endif
                end
            end
        end
    end

    task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, output int e);
        @(posedge clk); #1;
        start = 1'b1; a_in = a; b_in = b; cin = c;
        sb.push_back(model(a, b, c));
        @(posedge clk); #1;
        e = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int k = 0; k < 40 && n_done < target; k++) begin
            @(negedge clk); #2;
        end
        chk("done_timeout", n_done >= target, 1);
    endtask

    initial begin
        int st, n0, n;
        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum_out, 0);
        chk("rst_cout", cout, 0);
        rst = 1'b0;

        do_start(8'h5A, 8'h33, 1'b0, st);
        wait_done(1);
        chk("latency", done_edge[$] - st, W + 1);
        do_start(8'hFF, 8'h01, 1'b0, st);
        wait_done(2);
        do_start(8'hFF, 8'hFF, 1'b1, st);
        wait_done(3);
        do_start(8'h80, 8'h80, 1'b0, st);
        wait_done(4);
        repeat (5) @(posedge clk);
        #1;
        chk("hold_sum", sum_out, 8'h00);
        chk("hold_cout", cout, 1);
        chk("hold_done", done, 0);

        n0 = n_done;
        do_start(8'h11, 8'h22, 1'b0, st);
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; a_in = 8'hC3; b_in = 8'h7E; cin = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n0 + 1);
        repeat (15) @(posedge clk);
        #1;
        chk("ignore_done_count", n_done, n0 + 1);
        chk("ignore_sum_hold", sum_out, 8'h33);

        n0 = n_done;
        do_start(8'h12, 8'h34, 1'b1, st);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sum", sum_out, 0);
        chk("abort_cout", cout, 0);
        repeat (15) @(posedge clk);
        #1;
        chk("abort_no_done", n_done, n0);
        do_start(8'h7F, 8'h01, 1'b0, st);
        wait_done(n0 + 1);

        n0 = n_done;
        @(posedge clk); #1;
        start = 1'b1; a_in = 8'h0F; b_in = 8'hF1; cin = 1'b0;
        sb.push_back(model(8'h0F, 8'hF1, 1'b0));
        @(posedge clk); #1;
        a_in = 8'hA5; b_in = 8'h5A; cin = 1'b1;
        sb.push_back(model(8'hA5, 8'h5A, 1'b1));
        repeat (10) @(posedge clk);
        #1;
        a_in = 8'h40; b_in = 8'h40; cin = 1'b0;
        sb.push_back(model(8'h40, 8'h40, 1'b0));
        repeat (10) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n0 + 3);
        n = done_edge.size();
        if (n >= 3) begin
            chk("b2b_gap1", done_edge[n-2] - done_edge[n-3], W + 2);
            chk("b2b_gap2", done_edge[n-1] - done_edge[n-2], W + 2);
        end
        repeat (15) @(posedge clk);
        #1;
        chk("b2b_done_count", n_done, n0 + 3);
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
